// File: rtl/dot_channel_seq.sv
// dot_channel_seq: sequencer for one dot-channel slice. For every (cs, phase)
// weight group it accepts a feature window, runs the channel until it returns a
// result, and hands that result downstream tagged with cs/phase.
// Optional macro DCS_TIMEOUT_EN: aborts RUN to IDLE with a sticky err flag when
// the channel returns nothing within TIMEOUT cycles.
//
//   state   | meaning
//   IDLE    | waiting for start
//   WAIT_IN | in_ready high, waiting for the upstream window
//   RUN     | channel loading/computing, waiting for dc_valid
//   OUT     | result presented downstream, waiting for out_ready
//   DONE    | one-cycle completion pulse
module dot_channel_seq #(
  parameter int N_CS     = 9,
  parameter int N_PHASE  = 8,
  parameter int TIMEOUT  = 64,
  parameter int DATA_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                dc_load,
  output logic                ws_load,
  output logic [3:0]          cs,
  output logic [2:0]          phase,
  input  logic                dc_valid,
  input  logic [DATA_LEN-1:0] dc_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic [3:0]          out_cs,
  output logic [2:0]          out_phase,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [3:0] CS_LAST = 4'(N_CS - 1);
  localparam logic [2:0] PH_LAST = 3'(N_PHASE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    RUN     = 3'd2,
    OUT     = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   last_grp;
  logic   timeout;

  assign last_grp = (cs == CS_LAST) && (phase == PH_LAST);

`ifdef DCS_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer;

  assign timeout = (state == RUN) && !dc_valid && (timer == '0);

  // RUN watchdog: down-counter loaded on entry, err latched at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      err   <= 1'b0;
    end else begin
      if (state == WAIT_IN && in_valid)
        timer <= TMR_W'(TIMEOUT - 1);
      else if (state == RUN && timer != '0)
        timer <= timer - 1'b1;
      if (timeout)
        err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = WAIT_IN;
      WAIT_IN: if (in_valid) state_nxt = RUN;
      RUN: begin
        if (dc_valid)     state_nxt = OUT;
        else if (timeout) state_nxt = IDLE;
      end
      OUT:     if (out_ready) state_nxt = last_grp ? DONE : WAIT_IN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded purely from state
  always_comb begin
    in_ready  = 1'b0;
    dc_load   = 1'b0;
    ws_load   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      WAIT_IN: in_ready  = 1'b1;
      RUN: begin
        dc_load = 1'b1;
        ws_load = 1'b1;
      end
      OUT:     out_valid = 1'b1;
      DONE:    done      = 1'b1;
      default: ;
    endcase
  end

  // group counters and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs        <= '0;
      phase     <= '0;
      out_data  <= '0;
      out_cs    <= '0;
      out_phase <= '0;
    end else begin
      if (state == IDLE && start) begin
        cs    <= '0;
        phase <= '0;
      end else if (state == OUT && out_ready && !last_grp) begin
        if (phase == PH_LAST) begin
          phase <= '0;
          cs    <= cs + 1'b1;
        end else begin
          phase <= phase + 1'b1;
        end
      end
      if (state == RUN && dc_valid) begin
        out_data  <= dc_q;
        out_cs    <= cs;
        out_phase <= phase;
      end
    end
  end

endmodule

// File: tb/tb_dot_channel_seq.sv
// Bench for dot_channel_seq with a 2x2 sweep. A small channel model answers
// 3 cycles into each RUN with a value derived from (sweep, cs, phase); the
// expected results for each sweep are queued when start is driven and
// popped by a monitor on every accepted output.
module tb_dot_channel_seq;

  localparam int NC = 2;
  localparam int NP = 2;
  localparam int DL = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, in_valid, in_ready;
  logic          dc_load, ws_load;
  logic [3:0]    cs, out_cs;
  logic [2:0]    phase, out_phase;
  logic          dc_valid;
  logic [DL-1:0] dc_q, out_data;
  logic          out_valid, out_ready;
  logic          busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int res_cnt  = 0;
  logic [3:0] sweep_id = '0;
  logic       dc_block = 1'b0;
  logic [1:0] run_cnt;
  logic [22:0] sb[$];

  always #5 clk = ~clk;

  dot_channel_seq #(.N_CS(NC), .N_PHASE(NP), .TIMEOUT(64), .DATA_LEN(DL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .dc_load(dc_load), .ws_load(ws_load), .cs(cs), .phase(phase),
    .dc_valid(dc_valid), .dc_q(dc_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cs(out_cs), .out_phase(out_phase),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DL-1:0] dc_val(logic [3:0] sw, logic [3:0] c, logic [2:0] p);
    return 16'h3C5A ^ {sw, c, 5'b0, p};
  endfunction

  // channel model: result valid on the third consecutive load cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        run_cnt <= '0;
    else if (!dc_load) run_cnt <= '0;
    else if (run_cnt != 2'd3) run_cnt <= run_cnt + 1'b1;
  end
  assign dc_valid = dc_load && (run_cnt == 2'd2) && !dc_block;
  assign dc_q     = dc_val(sweep_id, cs, phase);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard monitor: handshake seen at negedge completes at next posedge
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      res_cnt++;
      if (sb.size() == 0) begin
        check("sb_extra_result", 32'd1, 32'd0);
      end else begin
        logic [22:0] e;
        e = sb.pop_front();
        check("out_data",  32'(out_data),  32'(e[22:7]));
        check("out_cs",    32'(out_cs),    32'(e[6:3]));
        check("out_phase", 32'(out_phase), 32'(e[2:0]));
      end
    end
  end

  task automatic push_sweep(input logic [3:0] sw);
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++)
        sb.push_back({dc_val(sw, 4'(c), 3'(p)), 4'(c), 3'(p)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check(tag, 32'd1, 32'd0);
  endtask

  task automatic wait_sig(input string tag, input int sel);
    int n = 0;
    logic hit;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(posedge clk); #1;
      n++;
      hit = (sel == 0) ? in_ready : (sel == 1) ? out_valid : dc_load;
    end
    if (!hit) check(tag, 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({in_ready, dc_load, ws_load, out_valid, busy, done, err}), 32'd0);
    check({tag, "_cs"}, 32'(cs), 32'd0);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_data"}, 32'({out_data, out_cs, out_phase}), 32'd0);
  endtask

  initial begin
    int d0, r0;
    logic [22:0] held;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // full sweep, no stalls
    sweep_id = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    d0 = done_cnt; r0 = res_cnt;
    push_sweep(sweep_id);
    pulse_start();
    wait_idle("sweep1_timeout", 300);
    @(negedge clk);
    check("sweep1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("sweep1_results", 32'(res_cnt - r0), 32'(NC * NP));
    check("sweep1_sb_empty", 32'(sb.size()), 32'd0);
    check("sweep1_busy", 32'(busy), 32'd0);

    // upstream stall in WAIT_IN, then downstream stall in OUT
    sweep_id = 4'd2; in_valid = 1'b0; out_ready = 1'b0;
    d0 = done_cnt;
    push_sweep(sweep_id);
    pulse_start();
    wait_sig("wait_in_reach", 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_load", 32'({dc_load, ws_load}), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1 in_valid = 1'b1;
    wait_sig("out_reach", 1);
    held = {out_data, out_cs, out_phase};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_hold", 32'({out_data, out_cs, out_phase}), 32'(held));
      check("stall_out_load", 32'(dc_load), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle("sweep2_timeout", 300);
    @(negedge clk);
    check("sweep2_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("sweep2_sb_empty", 32'(sb.size()), 32'd0);

    // start pulse while RUN is ignored
    sweep_id = 4'd3;
    d0 = done_cnt; r0 = res_cnt;
    push_sweep(sweep_id);
    pulse_start();
    wait_sig("run_reach", 2);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("sweep3_timeout", 300);
    @(negedge clk);
    check("sweep3_results", 32'(res_cnt - r0), 32'(NC * NP));
    check("sweep3_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("sweep3_busy_after", 32'(busy), 32'd0);

    // reset mid-RUN, then restart from (0,0)
    sweep_id = 4'd4;
    pulse_start();
    wait_sig("run_reach2", 2);
    @(posedge clk); #1;
    wait_sig("run_reach3", 2);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_all_zero("midrun_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    sweep_id = 4'd5;
    d0 = done_cnt; r0 = res_cnt;
    push_sweep(sweep_id);
    pulse_start();
    @(negedge clk);
    check("restart_cs_phase", 32'({cs, phase}), 32'd0);
    wait_idle("sweep5_timeout", 300);
    @(negedge clk);
    check("sweep5_results", 32'(res_cnt - r0), 32'(NC * NP));
    check("sweep5_sb_empty", 32'(sb.size()), 32'd0);

`ifdef DCS_TIMEOUT_EN
    // channel never answers: watchdog aborts to IDLE
    dc_block = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_idle("timeout_abort", 200);
    @(negedge clk);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    check("timeout_loads", 32'({dc_load, ws_load}), 32'd0);
    dc_block = 1'b0;
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
